// File: rtl/video_frame_probe_if.sv
// Pixel stream, probe control and published-result bundle between the
// composite RGB path and the frame probe.
interface video_frame_probe_if;
   logic            enable_i;
   logic [10:0]     screen_x_i;
   logic [9:0]      screen_y_i;
   logic [7:0]      r_i;
   logic [7:0]      g_i;
   logic [7:0]      b_i;
   logic [10:0]     probe_x_i;
   logic [9:0]      probe_y_i;
   logic            arm_i;
   logic            free_run_i;
   logic            busy_o;
   logic            done_o;
   logic [7:0][7:0] hex_values_o;
   logic [7:0]      status_bits_o;

   modport master (
      output enable_i, screen_x_i, screen_y_i, r_i, g_i, b_i,
             probe_x_i, probe_y_i, arm_i, free_run_i,
      input  busy_o, done_o, hex_values_o, status_bits_o
   );

   modport slave (
      input  enable_i, screen_x_i, screen_y_i, r_i, g_i, b_i,
             probe_x_i, probe_y_i, arm_i, free_run_i,
      output busy_o, done_o, hex_values_o, status_bits_o
   );
endinterface

// File: rtl/video_frame_probe.sv
// Once-per-frame probe of the composited RGB stream: probe pixel, window
// checksum and peak green, published as frame-stable bytes for the overlay.
module video_frame_probe #(
   parameter int WIN_W         = 16,
   parameter int WIN_H         = 8,
   parameter int NUM_HEX_BYTES = 8
) (
   input logic                clk_i,
   input logic                reset_i,
   video_frame_probe_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE} state_e;

   state_e state_q, state_d;
   logic   origin, origin_q, fs;
   logic   start, accum, publish;

   logic [10:0] px_q, px_d;
   logic [9:0]  py_q, py_d;
   logic        fr_q, fr_d;
   logic        hit_q, hit_d;
   logic [7:0]  pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
   logic [7:0]  gmax_q, gmax_d;
   logic [15:0] sum_q, sum_d;
   logic [15:0] wcount_q, wcount_d;
   logic        in_win, hit_now;

   logic [7:0]                    fcount_q, fcount_d;
   logic [NUM_HEX_BYTES-1:0][7:0] hex_q, hex_d;
   logic [7:0]                    status_q, status_d;
   logic                          done_q, busy_q;

   // Frame start is the rising edge of "at origin", so a parked (0,0) only fires once.
   assign origin = (bus.screen_x_i == 11'd0) && (bus.screen_y_i == 10'd0);
   assign fs     = origin && !origin_q;

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      accum   = 1'b0;
      publish = 1'b0;
      if (!bus.enable_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (bus.arm_i || bus.free_run_i) state_d = S_ARMED;
            S_ARMED:   if (fs) begin
                          state_d = S_CAPTURE;
                          start   = 1'b1;
                       end
            S_CAPTURE: if (fs) begin
                          publish = 1'b1;
                          if (bus.free_run_i) start = 1'b1;
                          else                state_d = S_IDLE;
                       end else begin
                          accum = 1'b1;
                       end
            default:   state_d = S_IDLE;
         endcase
      end
   end

   // The restart cycle judges window/hit against the freshly sampled origin.
   assign px_d    = start ? bus.probe_x_i : px_q;
   assign py_d    = start ? bus.probe_y_i : py_q;
   assign hit_now = (bus.screen_x_i == px_d) && (bus.screen_y_i == py_d);
   assign in_win  = (bus.screen_x_i >= px_d) &&
                    ({1'b0, bus.screen_x_i} < ({1'b0, px_d} + 12'(WIN_W))) &&
                    (bus.screen_y_i >= py_d) &&
                    ({1'b0, bus.screen_y_i} < ({1'b0, py_d} + 11'(WIN_H)));

   always_comb begin
      hit_d    = hit_q;
      pr_d     = pr_q;
      pg_d     = pg_q;
      pb_d     = pb_q;
      sum_d    = sum_q;
      gmax_d   = gmax_q;
      wcount_d = wcount_q;
      fr_d     = fr_q;
      if (start) begin
         hit_d    = 1'b0;
         pr_d     = 8'h00;
         pg_d     = 8'h00;
         pb_d     = 8'h00;
         sum_d    = 16'h0000;
         gmax_d   = 8'h00;
         wcount_d = 16'h0000;
         fr_d     = bus.free_run_i;
      end
      if (start || accum) begin
         if (hit_now) begin
            hit_d = 1'b1;
            pr_d  = bus.r_i;
            pg_d  = bus.g_i;
            pb_d  = bus.b_i;
         end
         if (in_win) begin
            sum_d = sum_d + {bus.r_i ^ bus.b_i, bus.g_i};
            if (bus.g_i > gmax_d) gmax_d = bus.g_i;
            if (wcount_d != 16'hFFFF) wcount_d = wcount_d + 16'd1;
         end
      end
   end

   always_comb begin
      fcount_d = fcount_q + 8'd1;
      hex_d[0] = hit_q ? pr_q : 8'h00;
      hex_d[1] = hit_q ? pg_q : 8'h00;
      hex_d[2] = hit_q ? pb_q : 8'h00;
      hex_d[3] = sum_q[15:8];
      hex_d[4] = sum_q[7:0];
      hex_d[5] = gmax_q;
      hex_d[6] = fcount_d;
      hex_d[7] = wcount_q[7:0];
      status_d = {~hit_q, (wcount_q == 16'h0000), (wcount_q == 16'hFFFF), fr_q, 4'b0000};
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         origin_q <= 1'b0;
         px_q     <= '0;
         py_q     <= '0;
         fr_q     <= 1'b0;
         hit_q    <= 1'b0;
         pr_q     <= '0;
         pg_q     <= '0;
         pb_q     <= '0;
         sum_q    <= '0;
         gmax_q   <= '0;
         wcount_q <= '0;
      end else begin
         state_q  <= state_d;
         origin_q <= origin;
         px_q     <= px_d;
         py_q     <= py_d;
         fr_q     <= fr_d;
         hit_q    <= hit_d;
         pr_q     <= pr_d;
         pg_q     <= pg_d;
         pb_q     <= pb_d;
         sum_q    <= sum_d;
         gmax_q   <= gmax_d;
         wcount_q <= wcount_d;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         fcount_q <= '0;
         hex_q    <= '0;
         status_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= publish;
         busy_q <= (state_d != S_IDLE);
         if (publish) begin
            fcount_q <= fcount_d;
            hex_q    <= hex_d;
            status_q <= status_d;
         end
      end
   end

   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;
   assign bus.hex_values_o  = hex_q;
   assign bus.status_bits_o = status_q;
endmodule
